// File: rtl/fir_seq_ctrl_if.sv
// Queue / coefficient ROM / output bundle for the FIR frame sequencer.
// The master side is the queue, ROM and downstream stage; the slave side is fir_seq_ctrl.
interface fir_seq_ctrl_if #(
    parameter int CA_W = 10
);
    logic            sequencing;
    logic [15:0]     lft_smpl;
    logic [15:0]     rght_smpl;
    logic [15:0]     coeff;
    logic [CA_W-1:0] coeff_addr;
    logic [15:0]     lft_out;
    logic [15:0]     rght_out;
    logic            vld;
    logic            len_err;
    logic            frm_drop;
    logic            busy;

    modport master (
        output sequencing, lft_smpl, rght_smpl, coeff,
        input  coeff_addr, lft_out, rght_out, vld, len_err, frm_drop, busy
    );

    modport slave (
        input  sequencing, lft_smpl, rght_smpl, coeff,
        output coeff_addr, lft_out, rght_out, vld, len_err, frm_drop, busy
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// One FIR pass per queue read burst: ROM address in lockstep, 3-stage L/R MAC, saturated Q1.15 output.
//   state | meaning
//   IDLE  | waiting for a sequencing burst; coeff_addr held at 0
//   RUN   | burst in progress; taps accepted until NUM_TAPS reached
//   FLUSH | pipeline drain (3 cycles), then waits out any dropped burst
module fir_seq_ctrl #(
    parameter int NUM_TAPS = 1021,
    parameter int CA_W     = 10,
    parameter int ACC_W    = 40
) (
    input  logic          clk,
    input  logic          rst,
    fir_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CA_W:0]   TAPS        = (CA_W+1)'(NUM_TAPS);
    localparam logic [CA_W-1:0] ADDR_MAX    = CA_W'(NUM_TAPS - 1);
    localparam logic [1:0]      FLUSH_START = 2'd2;

    state_t                    state_q, state_d;
    logic [CA_W:0]             tap_cnt_q, tap_cnt_d;
    logic                      ovf_q, ovf_d;
    logic [1:0]                flush_cnt_q, flush_cnt_d;
    logic                      seq_prev_q, seq_prev_d;
    logic                      seq_d1_q, seq_d1_d;
    logic                      s_vld_q, s_vld_d;
    logic                      p_vld_q, p_vld_d;
    logic signed [15:0]        lsmp_q, lsmp_d, rsmp_q, rsmp_d, coef_q, coef_d;
    logic signed [31:0]        lprod_q, lprod_d, rprod_q, rprod_d;
    logic signed [ACC_W-1:0]   lacc_q, lacc_d, racc_q, racc_d;
    logic [15:0]               lft_out_q, lft_out_d, rght_out_q, rght_out_d;
    logic                      vld_q, vld_d;
    logic                      len_err_q, len_err_d;
    logic                      frm_drop_q, frm_drop_d;

    logic start;
    logic accept;

    // Clamp instead of wrapping so a full-scale frame still saturates the right way.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [31:0] p);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W-31){p[31]}}, p};
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    function automatic logic [15:0] scale(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1:30] == '0 || a[ACC_W-1:30] == '1)
            scale = a[30:15];
        else
            scale = a[ACC_W-1] ? 16'h8000 : 16'h7FFF;
    endfunction

    assign start  = (state_q == IDLE) && bus.sequencing;
    assign accept = start || ((state_q == RUN) && bus.sequencing && (tap_cnt_q < TAPS));

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        ovf_d       = ovf_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.sequencing) begin
                    state_d   = RUN;
                    tap_cnt_d = (CA_W+1)'(1);
                    ovf_d     = 1'b0;
                end
            end
            RUN: begin
                if (!bus.sequencing) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_START;
                end else if (tap_cnt_q < TAPS) begin
                    tap_cnt_d = tap_cnt_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q != 2'd0)
                    flush_cnt_d = flush_cnt_q - 1'b1;
                else if (!bus.sequencing)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        seq_prev_d = bus.sequencing;
        seq_d1_d   = accept;
        s_vld_d    = seq_d1_q;
        p_vld_d    = s_vld_q;
        lsmp_d     = seq_d1_q ? $signed(bus.lft_smpl)  : lsmp_q;
        rsmp_d     = seq_d1_q ? $signed(bus.rght_smpl) : rsmp_q;
        coef_d     = seq_d1_q ? $signed(bus.coeff)     : coef_q;
        lprod_d    = s_vld_q ? 32'(lsmp_q) * 32'(coef_q) : lprod_q;
        rprod_d    = s_vld_q ? 32'(rsmp_q) * 32'(coef_q) : rprod_q;

        if (start) begin
            lacc_d = '0;
            racc_d = '0;
        end else if (p_vld_q) begin
            lacc_d = sat_add(lacc_q, lprod_q);
            racc_d = sat_add(racc_q, rprod_q);
        end else begin
            lacc_d = lacc_q;
            racc_d = racc_q;
        end

        // Output latches the final accumulate on the same edge, so vld lands on the last FLUSH cycle.
        vld_d      = (state_q == FLUSH) && (flush_cnt_q == 2'd1);
        lft_out_d  = vld_d ? scale(lacc_d) : lft_out_q;
        rght_out_d = vld_d ? scale(racc_d) : rght_out_q;
        len_err_d  = vld_d ? ((tap_cnt_q != TAPS) || ovf_q) : len_err_q;
        frm_drop_d = (state_q == FLUSH) && bus.sequencing && !seq_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tap_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            flush_cnt_q <= '0;
            seq_prev_q  <= 1'b0;
            seq_d1_q    <= 1'b0;
            s_vld_q     <= 1'b0;
            p_vld_q     <= 1'b0;
            lsmp_q      <= '0;
            rsmp_q      <= '0;
            coef_q      <= '0;
            lprod_q     <= '0;
            rprod_q     <= '0;
            lacc_q      <= '0;
            racc_q      <= '0;
            lft_out_q   <= '0;
            rght_out_q  <= '0;
            vld_q       <= 1'b0;
            len_err_q   <= 1'b0;
            frm_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            ovf_q       <= ovf_d;
            flush_cnt_q <= flush_cnt_d;
            seq_prev_q  <= seq_prev_d;
            seq_d1_q    <= seq_d1_d;
            s_vld_q     <= s_vld_d;
            p_vld_q     <= p_vld_d;
            lsmp_q      <= lsmp_d;
            rsmp_q      <= rsmp_d;
            coef_q      <= coef_d;
            lprod_q     <= lprod_d;
            rprod_q     <= rprod_d;
            lacc_q      <= lacc_d;
            racc_q      <= racc_d;
            lft_out_q   <= lft_out_d;
            rght_out_q  <= rght_out_d;
            vld_q       <= vld_d;
            len_err_q   <= len_err_d;
            frm_drop_q  <= frm_drop_d;
        end
    end

    assign bus.coeff_addr = (state_q != RUN)  ? '0 :
                            (tap_cnt_q >= TAPS) ? ADDR_MAX : tap_cnt_q[CA_W-1:0];
    assign bus.lft_out    = lft_out_q;
    assign bus.rght_out   = rght_out_q;
    assign bus.vld        = vld_q;
    assign bus.len_err    = len_err_q;
    assign bus.frm_drop   = frm_drop_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: directed and random frames, expected results queued at issue
// and checked by an independent monitor whenever vld pulses.
module tb_fir_seq_ctrl;
    localparam int NUM_TAPS = 1021;
    localparam int CA_W     = 10;
    localparam int ACC_W    = 40;
    localparam int MAXN     = 1200;

    logic clk = 1'b0;
    logic rst;

    fir_seq_ctrl_if #(.CA_W(CA_W)) bus();

    fir_seq_ctrl #(.NUM_TAPS(NUM_TAPS), .CA_W(CA_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        le;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          drops_seen = 0;
    int          exp_drops = 0;

    logic [15:0]     rom   [0:1023];
    logic [15:0]     l_smp [0:MAXN-1];
    logic [15:0]     r_smp [0:MAXN-1];
    logic [CA_W-1:0] addr_prev = '0;

    // ROM with one cycle of read latency: address seen mid-cycle k, data driven mid-cycle k+1.
    always @(negedge clk) begin
        bus.coeff = rom[addr_prev];
        addr_prev = bus.coeff_addr;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frm_drop) drops_seen++;
            if (bus.vld) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_vld: got vld with empty scoreboard, expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("vld_cycle", longint'(cyc), longint'(mon_e.cyc));
                    check("lft_out", bus.lft_out, mon_e.l);
                    check("rght_out", bus.rght_out, mon_e.r);
                    check("len_err", bus.len_err, mon_e.le);
                end
            end
        end
    end

    function automatic logic [15:0] to_out(input longint a);
        longint lim;
        lim = longint'(1) <<< 30;
        if (a >= lim)  return 16'h7FFF;
        if (a < -lim)  return 16'h8000;
        return 16'(a >>> 15);
    endfunction

    // Reference: dot product over the first min(n, NUM_TAPS) taps, clamped to the accumulator range.
    function automatic logic [15:0] model_out(input bit right, input int n);
        longint acc, amax, amin, p;
        int taps;
        logic [15:0] s;
        amax = (longint'(1) <<< (ACC_W-1)) - 1;
        amin = -(longint'(1) <<< (ACC_W-1));
        taps = (n < NUM_TAPS) ? n : NUM_TAPS;
        acc  = 0;
        for (int k = 0; k < taps; k++) begin
            s   = right ? r_smp[k] : l_smp[k];
            p   = longint'($signed(s)) * longint'($signed(rom[k]));
            acc = acc + p;
            if (acc > amax) acc = amax;
            if (acc < amin) acc = amin;
        end
        return to_out(acc);
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 1024; k++) rom[k] = 16'($urandom);
        for (int k = 0; k < MAXN; k++) begin
            l_smp[k] = 16'($urandom);
            r_smp[k] = 16'($urandom);
        end
    endtask

    task automatic run_burst(input int n, input bit fixed, input logic [15:0] fl, input logic [15:0] fr);
        int unsigned start;
        exp_t e;
        @(negedge clk);
        start = cyc;
        for (int k = 0; k <= n; k++) begin
            bus.sequencing = (k < n);
            bus.lft_smpl   = (k > 0) ? l_smp[k-1] : 16'($urandom);
            bus.rght_smpl  = (k > 0) ? r_smp[k-1] : 16'($urandom);
            if (k < n) begin
                #1;
                check("coeff_addr", bus.coeff_addr, (k < NUM_TAPS) ? k : NUM_TAPS - 1);
                if (k == 1) check("busy_run", bus.busy, 1);
            end
            @(negedge clk);
        end
        bus.lft_smpl  = 16'($urandom);
        bus.rght_smpl = 16'($urandom);
        e.l   = fixed ? fl : model_out(1'b0, n);
        e.r   = fixed ? fr : model_out(1'b1, n);
        e.le  = (n != NUM_TAPS);
        e.cyc = start + n + 3;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || bus.busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (t >= 3000) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.sequencing = 1'b0;
        bus.lft_smpl   = '0;
        bus.rght_smpl  = '0;
        for (int k = 0; k < 1024; k++) rom[k] = '0;
        for (int k = 0; k < MAXN; k++) begin
            l_smp[k] = '0;
            r_smp[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_vld", bus.vld, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_lft_out", bus.lft_out, 0);
        check("rst_rght_out", bus.rght_out, 0);
        check("rst_coeff_addr", bus.coeff_addr, 0);
        check("rst_len_err", bus.len_err, 0);
        check("rst_frm_drop", bus.frm_drop, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // impulse
        rom[0]   = 16'h7FFF;
        l_smp[0] = 16'h4000;
        r_smp[0] = 16'hC000;
        run_burst(NUM_TAPS, 1'b1, 16'h3FFF, 16'hC000);
        wait_idle();

        // full-scale saturation
        for (int k = 0; k < 1024; k++) rom[k] = 16'h7FFF;
        for (int k = 0; k < MAXN; k++) begin
            l_smp[k] = 16'h7FFF;
            r_smp[k] = 16'h8000;
        end
        run_burst(NUM_TAPS, 1'b1, 16'h7FFF, 16'h8000);
        wait_idle();

        // short, long, exact
        fill_random();
        run_burst(500, 1'b0, '0, '0);
        wait_idle();
        fill_random();
        run_burst(1030, 1'b0, '0, '0);
        wait_idle();
        fill_random();
        run_burst(NUM_TAPS, 1'b0, '0, '0);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            fill_random();
            run_burst(int'($urandom_range(1, 1100)), 1'b0, '0, '0);
            wait_idle();
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // re-rise during FLUSH is dropped, first frame still reported
        fill_random();
        run_burst(40, 1'b0, '0, '0);
        bus.sequencing = 1'b1;
        exp_drops++;
        repeat (8) @(negedge clk);
        bus.sequencing = 1'b0;
        wait_idle();

        // reset mid-burst
        fill_random();
        @(negedge clk);
        for (int k = 0; k < 600; k++) begin
            bus.sequencing = 1'b1;
            bus.lft_smpl   = 16'($urandom);
            bus.rght_smpl  = 16'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        bus.sequencing = 1'b0;
        #1;
        check("midrst_lft_out", bus.lft_out, 0);
        check("midrst_rght_out", bus.rght_out, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_coeff_addr", bus.coeff_addr, 0);
        check("midrst_vld", bus.vld, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fill_random();
        run_burst(NUM_TAPS, 1'b0, '0, '0);
        wait_idle();
        repeat (5) @(negedge clk);

        check("frm_drop_count", drops_seen, exp_drops);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
